// File: rtl/uart_seq_pkg.sv
// ---------------------------------------------------------------------------
// uart_seq_pkg
// Shared definitions for the UART-over-ICB sequencer:
//   - default UART register map (CSR / CTRL / DATA) and the CSR "rx byte
//     available" bit position,
//   - default poll budget and poll counter width,
//   - sequencer state enum and single-transaction phase enum.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_seq_pkg;

  localparam logic [31:0] UART_CSR_ADDR  = 32'h0000_0000;
  localparam logic [31:0] UART_CTRL_ADDR = 32'h0000_0004;
  localparam logic [31:0] UART_DATA_ADDR = 32'h0000_0008;

  localparam int unsigned UART_STAT_BIT = 4;
  localparam int unsigned UART_POLL_MAX = 1024;

  // 11 bits covers POLL_MAX up to 2048; the counter never exceeds POLL_MAX-1.
  localparam int unsigned POLL_CNT_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG_CSR  = 3'd1,
    ST_CFG_CTRL = 3'd2,
    ST_READY    = 3'd3,
    ST_WR_DATA  = 3'd4,
    ST_POLL     = 3'd5,
    ST_RD_DATA  = 3'd6,
    ST_OUT      = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_CMD  = 2'd1,
    PH_RSP  = 2'd2
  } xact_phase_e;

endpackage

// File: rtl/uart_icb_xact.sv
// ---------------------------------------------------------------------------
// uart_icb_xact
// Runs exactly one ICB transaction at a time: a CMD phase (valid held with
// stable addr/read/wdata until ready) followed by an RSP phase (rsp_ready
// held until rsp_valid).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request a transaction; accepted when idle or in the
//                       cycle the previous response completes
//   addr/read/wdata     transaction attributes, captured on acceptance
//   done                one-cycle pulse on the response handshake
//   rdata               response data, valid while done=1
//   icb_cmd_*           ICB command channel (master side)
//   icb_rsp_*           ICB response channel (master side)
// ---------------------------------------------------------------------------
module uart_icb_xact
  import uart_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        read,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [31:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata
);

  xact_phase_e phase_q, phase_d;
  logic [31:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;

  assign done  = (phase_q == PH_RSP) && icb_rsp_valid;
  assign rdata = icb_rsp_rdata;

  // A new command may be accepted in the very cycle the previous response
  // lands, so back-to-back transactions have no idle gap; there is still
  // never more than one outstanding.
  assign accept = (phase_q == PH_IDLE) || done;

  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    read_d  = read_q;
    wdata_d = wdata_q;
    case (phase_q)
      PH_CMD: if (icb_cmd_ready) phase_d = PH_RSP;
      PH_RSP: if (icb_rsp_valid) phase_d = PH_IDLE;
      default: ;
    endcase
    if (start && accept) begin
      phase_d = PH_CMD;
      addr_d  = addr;
      read_d  = read;
      wdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      wdata_q <= wdata_d;
    end
  end

  assign icb_cmd_valid = (phase_q == PH_CMD);
  assign icb_cmd_addr  = addr_q;
  assign icb_cmd_read  = read_q;
  assign icb_cmd_wdata = wdata_q;
  assign icb_rsp_ready = (phase_q == PH_RSP);

endmodule

// File: rtl/uart_icb_seq.sv
// ---------------------------------------------------------------------------
// uart_icb_seq
// Drives a memory-mapped UART over an ICB bus: writes CSR and CTRL on
// cfg_start, then for each tx byte writes DATA, polls CSR until the rx-ready
// bit is set (bounded by POLL_MAX), reads DATA and presents the byte on the
// rx handshake.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_start, cfg_csr, cfg_ctrl  configuration request and register values
//   cfg_done                    configuration complete (level)
//   busy                        high outside IDLE/READY
//   err_timeout                 sticky: CSR poll budget exhausted
//   tx_valid/tx_ready/tx_data   byte-in handshake
//   rx_valid/rx_ready/rx_data   byte-out handshake
//   icb_cmd_*, icb_rsp_*        ICB master interface
// ---------------------------------------------------------------------------
module uart_icb_seq
  import uart_seq_pkg::*;
#(
  parameter logic [31:0] CSR_ADDR  = UART_CSR_ADDR,
  parameter logic [31:0] CTRL_ADDR = UART_CTRL_ADDR,
  parameter logic [31:0] DATA_ADDR = UART_DATA_ADDR,
  parameter int unsigned STAT_BIT  = UART_STAT_BIT,
  parameter int unsigned POLL_MAX  = UART_POLL_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [31:0] cfg_csr,
  input  logic [31:0] cfg_ctrl,
  output logic        cfg_done,
  output logic        busy,
  output logic        err_timeout,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [7:0]  tx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        icb_cmd_valid,
  input  logic        icb_cmd_ready,
  output logic [31:0] icb_cmd_addr,
  output logic        icb_cmd_read,
  output logic [31:0] icb_cmd_wdata,
  input  logic        icb_rsp_valid,
  output logic        icb_rsp_ready,
  input  logic [31:0] icb_rsp_rdata
);

  localparam logic [POLL_CNT_W:0] POLL_LIMIT = (POLL_CNT_W+1)'(POLL_MAX);

  seq_state_e            state_q, state_d;
  logic [POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  cfg_done_q, cfg_done_d;
  logic                  err_timeout_q, err_timeout_d;

  logic                  x_start;
  logic [31:0]           x_addr;
  logic                  x_read;
  logic [31:0]           x_wdata;
  logic                  x_done;
  logic [31:0]           x_rdata;

  logic                  go_cfg;
  logic [POLL_CNT_W:0]   poll_next;

  // Only the status bit and the low data byte matter; the rest of the
  // response word is deliberately dropped.
  logic                  unused_rdata;
  assign unused_rdata = ^x_rdata;

  assign go_cfg    = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_READY));
  assign poll_next = {1'b0, poll_cnt_q} + 1'b1;

  // Each bus state issues its command in the cycle the state is entered:
  // x_start is raised on the transition into it (or on a re-poll), so the
  // command appears on the bus one cycle later.
  always_comb begin
    state_d       = state_q;
    poll_cnt_d    = poll_cnt_q;
    rx_data_d     = rx_data_q;
    cfg_done_d    = cfg_done_q;
    err_timeout_d = err_timeout_q;
    x_start       = 1'b0;
    x_addr        = CSR_ADDR;
    x_read        = 1'b0;
    x_wdata       = '0;

    if (go_cfg) begin
      state_d       = ST_CFG_CSR;
      cfg_done_d    = 1'b0;
      err_timeout_d = 1'b0;
      x_start       = 1'b1;
      x_addr        = CSR_ADDR;
      x_wdata       = cfg_csr;
    end else begin
      case (state_q)
        ST_CFG_CSR: if (x_done) begin
          state_d = ST_CFG_CTRL;
          x_start = 1'b1;
          x_addr  = CTRL_ADDR;
          x_wdata = cfg_ctrl;
        end
        ST_CFG_CTRL: if (x_done) begin
          state_d    = ST_READY;
          cfg_done_d = 1'b1;
        end
        ST_READY: if (tx_valid) begin
          state_d = ST_WR_DATA;
          x_start = 1'b1;
          x_addr  = DATA_ADDR;
          x_wdata = {24'b0, tx_data};
        end
        ST_WR_DATA: if (x_done) begin
          state_d    = ST_POLL;
          poll_cnt_d = '0;
          x_start    = 1'b1;
          x_addr     = CSR_ADDR;
          x_read     = 1'b1;
        end
        ST_POLL: if (x_done) begin
          if (x_rdata[STAT_BIT]) begin
            state_d = ST_RD_DATA;
            x_start = 1'b1;
            x_addr  = DATA_ADDR;
            x_read  = 1'b1;
          end else if (poll_next < POLL_LIMIT) begin
            poll_cnt_d = poll_next[POLL_CNT_W-1:0];
            x_start    = 1'b1;
            x_addr     = CSR_ADDR;
            x_read     = 1'b1;
          end else begin
            state_d       = ST_READY;
            err_timeout_d = 1'b1;
          end
        end
        ST_RD_DATA: if (x_done) begin
          state_d   = ST_OUT;
          rx_data_d = x_rdata[7:0];
        end
        ST_OUT: if (rx_ready) state_d = ST_READY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      poll_cnt_q    <= '0;
      rx_data_q     <= '0;
      cfg_done_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      poll_cnt_q    <= poll_cnt_d;
      rx_data_q     <= rx_data_d;
      cfg_done_q    <= cfg_done_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  uart_icb_xact u_xact (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (x_start),
    .addr          (x_addr),
    .read          (x_read),
    .wdata         (x_wdata),
    .done          (x_done),
    .rdata         (x_rdata),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata)
  );

  // A simultaneous cfg_start wins over a tx byte in READY, so tx_ready is
  // withheld in that cycle rather than accepting a byte that would be lost.
  assign tx_ready    = (state_q == ST_READY) && !cfg_start;
  assign rx_valid    = (state_q == ST_OUT);
  assign rx_data     = rx_data_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_READY);
  assign cfg_done    = cfg_done_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_icb_seq.sv
// ---------------------------------------------------------------------------
// tb_uart_icb_seq
// Directed bench for uart_icb_seq with a small ICB slave model (configurable
// command stall, number of CSR polls before the rx bit appears, and a switch
// that withholds CSR read responses). The DUT runs with POLL_MAX=4.
// ---------------------------------------------------------------------------
module tb_uart_icb_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_csr = '0;
  logic [31:0] cfg_ctrl = '0;
  logic        cfg_done;
  logic        busy;
  logic        err_timeout;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data = '0;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready = 1'b1;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic        icb_rsp_valid = 1'b0;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata = '0;

  always #5 clk = ~clk;

  uart_icb_seq #(
    .POLL_MAX (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_csr       (cfg_csr),
    .cfg_ctrl      (cfg_ctrl),
    .cfg_done      (cfg_done),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .icb_cmd_valid (icb_cmd_valid),
    .icb_cmd_ready (icb_cmd_ready),
    .icb_cmd_addr  (icb_cmd_addr),
    .icb_cmd_read  (icb_cmd_read),
    .icb_cmd_wdata (icb_cmd_wdata),
    .icb_rsp_valid (icb_rsp_valid),
    .icb_rsp_ready (icb_rsp_ready),
    .icb_rsp_rdata (icb_rsp_rdata)
  );

  wire [79:0] all_outs = {cfg_done, busy, err_timeout, tx_ready, rx_valid, rx_data,
                          icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
                          icb_rsp_ready};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- ICB slave model ----------------
  int          cmd_stall  = 0;
  int          stall_cnt  = 0;
  int          stat_after = 1;
  int          csr_polls  = 0;
  bit          mute_csr   = 0;
  bit          cv, cmd_fire, rsp_fire;
  logic [31:0] f_addr, f_wdata;
  logic        f_read;
  logic [7:0]  last_wr = '0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic        log_read[$];
  int          last_rsp_cyc = -10;
  bit          hold_v = 0;
  logic [31:0] hold_addr, hold_wdata;
  int          stab_bad = 0;

  // Mid-cycle: note what will handshake at the next rising edge.
  always @(negedge clk) begin
    cv       = (icb_cmd_valid === 1'b1);
    cmd_fire = cv && (icb_cmd_ready === 1'b1);
    rsp_fire = (icb_rsp_valid === 1'b1) && (icb_rsp_ready === 1'b1);
    if (rsp_fire) last_rsp_cyc = cyc;
    if (cv) begin
      if (!hold_v) begin
        hold_v     = 1;
        hold_addr  = icb_cmd_addr;
        hold_wdata = icb_cmd_wdata;
      end else if (icb_cmd_addr !== hold_addr || icb_cmd_wdata !== hold_wdata) begin
        stab_bad++;
      end
    end
    if (cmd_fire) begin
      hold_v  = 0;
      f_addr  = icb_cmd_addr;
      f_read  = icb_cmd_read;
      f_wdata = icb_cmd_wdata;
      log_addr.push_back(f_addr);
      log_read.push_back(f_read);
      log_wdata.push_back(f_wdata);
      $display("icb %s addr=%08h wdata=%08h cyc=%0d", f_read ? "rd" : "wr", f_addr, f_wdata, cyc);
    end
  end

  // Just after the edge: retire the response, schedule the next one.
  always @(posedge clk) begin
    logic [31:0] rd;
    #1;
    if (rsp_fire) icb_rsp_valid = 1'b0;
    if (cmd_fire) begin
      stall_cnt = 0;
      rd = 32'hBAD0_0000;
      if (f_read && f_addr == 32'h0) begin
        csr_polls++;
        // noisy upper bits, bit 4 only when the byte is "received"
        rd = 32'hDEAD_BE00 | ((csr_polls >= stat_after) ? 32'h10 : 32'h0);
      end else if (f_read) begin
        rd = 32'h1234_5600 | {24'h0, last_wr};
      end else if (f_addr == 32'h8) begin
        last_wr   = f_wdata[7:0];
        csr_polls = 0;
      end
      if (!(mute_csr && f_read && f_addr == 32'h0)) begin
        icb_rsp_valid = 1'b1;
        icb_rsp_rdata = rd;
      end
    end else if (cv) begin
      stall_cnt++;
    end
    icb_cmd_ready = (stall_cnt >= cmd_stall);
  end

  task automatic clear_log();
    log_addr.delete();
    log_read.delete();
    log_wdata.delete();
  endtask

  // ---------------- stimulus tasks ----------------
  task automatic do_cfg(input logic [31:0] csr, input logic [31:0] ctrl,
                        output int t, output logic d0, output logic e0);
    @(posedge clk); #1;
    cfg_csr = csr; cfg_ctrl = ctrl; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    d0 = cfg_done;
    e0 = err_timeout;
    t  = -1;
    for (int i = 0; i < 200; i++) begin
      if (cfg_done) begin t = cyc; break; end
      @(negedge clk);
    end
    chk("cfg_done_seen", t >= 0, 1'b1);
  endtask

  // Send one byte; hold rx_ready low for 'stall' extra cycles once rx_valid
  // shows. lat counts cycles from the tx handshake cycle to the first rx_valid
  // cycle, both inclusive. viol counts cycles where rx was pending but the
  // byte changed, tx_ready was offered, or the bus was active.
  task automatic xfer(input logic [7:0] b, input int stall, output logic [7:0] got,
                      output bit ok, output int lat, output int viol);
    int t0;
    bit hs;
    t0 = 0; hs = 0; ok = 0; got = '0; lat = 0; viol = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = b; rx_ready = 1'b0;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      if (tx_ready) begin hs = 1; t0 = cyc; end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    chk("tx_handshake", hs, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_valid) begin ok = 1; lat = cyc - t0 + 1; got = rx_data; break; end
      if (tx_ready) break;
    end
    if (ok) begin
      if (tx_ready || icb_cmd_valid) viol++;
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        if (!rx_valid || tx_ready || icb_cmd_valid || rx_data !== got) viol++;
      end
      @(posedge clk); #1;
      rx_ready = 1'b1;
      @(negedge clk);
      if (!rx_valid || tx_ready) viol++;
      @(posedge clk); #1;
      rx_ready = 1'b0;
    end
  endtask

  task automatic chk_loop_log(input string p);
    chk({p, "_nxact"}, log_addr.size(), 5);
    if (log_addr.size() == 5) begin
      chk({p, "_wr_addr"},  log_addr[0],  32'h8);
      chk({p, "_wr_data"},  log_wdata[0], 32'h0000_00A5);
      chk({p, "_wr_read"},  log_read[0],  1'b0);
      for (int i = 1; i <= 3; i++) begin
        chk({p, "_poll_addr"}, log_addr[i], 32'h0);
        chk({p, "_poll_read"}, log_read[i], 1'b1);
      end
      chk({p, "_rd_addr"}, log_addr[4], 32'h8);
      chk({p, "_rd_read"}, log_read[4], 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] got;
    bit         ok;
    int         lat, viol, viol_tot, t, n;
    logic       d0, e0;

    // reset state and quiet bus afterwards
    repeat (3) @(negedge clk);
    chk("rst_outputs_zero", all_outs, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_cmd_before_cfg", log_addr.size(), 0);
    chk("idle_not_busy", busy, 1'b0);
    chk("idle_no_tx_ready", tx_ready, 1'b0);

    // configuration
    clear_log();
    do_cfg(32'h0008_0201, 32'h0001_0111, t, d0, e0);
    chk("cfg_done_low_during", d0, 1'b0);
    chk("cfg_nxact", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("cfg_csr_addr",  log_addr[0],  32'h0);
      chk("cfg_csr_data",  log_wdata[0], 32'h0008_0201);
      chk("cfg_csr_write", log_read[0],  1'b0);
      chk("cfg_ctrl_addr", log_addr[1],  32'h4);
      chk("cfg_ctrl_data", log_wdata[1], 32'h0001_0111);
    end
    chk("cfg_done_lat", t, last_rsp_cyc + 1);
    @(negedge clk);
    chk("ready_tx_ready", tx_ready, 1'b1);

    // single-poll latency
    clear_log();
    stat_after = 1;
    xfer(8'h3C, 0, got, ok, lat, viol);
    chk("lat_rx_seen", ok, 1'b1);
    chk("lat_rx_data", got, 8'h3C);
    chk("lat_cycles", lat, 8);
    chk("lat_nxact", log_addr.size(), 3);

    // loopback with three polls
    clear_log();
    stat_after = 3;
    xfer(8'hA5, 2, got, ok, lat, viol);
    chk("loop_rx_seen", ok, 1'b1);
    chk("loop_rx_data", got, 8'hA5);
    chk("loop_pending", viol, 0);
    chk_loop_log("loop");

    // same with command backpressure
    clear_log();
    cmd_stall = 5;
    stab_bad  = 0;
    xfer(8'hA5, 0, got, ok, lat, viol);
    chk("bp_rx_seen", ok, 1'b1);
    chk("bp_rx_data", got, 8'hA5);
    chk("bp_cmd_stable", stab_bad, 0);
    chk("bp_lat_longer", lat > 8 + 5 * 4, 1'b1);
    chk_loop_log("bp");
    cmd_stall = 0;

    // poll timeout
    clear_log();
    stat_after = 100;
    xfer(8'h5A, 0, got, ok, lat, viol);
    chk("to_no_rx", ok, 1'b0);
    n = 0;
    foreach (log_addr[i]) if (log_read[i] && log_addr[i] == 32'h0) n++;
    chk("to_csr_reads", n, 4);
    @(negedge clk);
    chk("to_err", err_timeout, 1'b1);
    chk("to_tx_ready", tx_ready, 1'b1);
    chk("to_not_busy", busy, 1'b0);

    // reconfigure from READY clears the sticky error
    clear_log();
    do_cfg(32'h0000_1234, 32'h0000_5678, t, d0, e0);
    chk("recfg_err_cleared", e0, 1'b0);
    chk("recfg_done_cleared", d0, 1'b0);
    chk("recfg_nxact", log_addr.size(), 2);

    // stream 256 bytes with random rx backpressure
    stat_after = 1;
    viol_tot = 0;
    for (int b = 0; b < 256; b++) begin
      xfer(8'(b), int'($urandom_range(0, 3)), got, ok, lat, viol);
      chk("stream_rx", {ok, got}, {1'b1, 8'(b)});
      viol_tot += viol;
    end
    chk("stream_pending", viol_tot, 0);

    // reset in the middle of POLL with a response outstanding
    clear_log();
    stat_after = 100;
    mute_csr   = 1;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = 8'h77;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready) ok = 1;
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (log_addr.size() >= 2) ok = 1;
    end
    chk("mid_poll_reached", ok, 1'b1);
    @(negedge clk);
    chk("mid_poll_rsp_wait", icb_rsp_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    icb_rsp_valid = 1'b1;
    icb_rsp_rdata = 32'h0000_0010;
    @(negedge clk);
    chk("mid_rst_outputs_zero", all_outs, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if (icb_rsp_ready || icb_cmd_valid || busy || rx_valid) n++;
    end
    chk("late_rsp_ignored", n, 0);
    chk("late_no_cmd", log_addr.size(), 2);
    @(posedge clk); #1;
    icb_rsp_valid = 1'b0;
    mute_csr = 0;
    clear_log();
    do_cfg(32'h0008_0201, 32'h0001_0111, t, d0, e0);
    chk("post_rst_nxact", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("post_rst_csr", {log_addr[0], log_wdata[0]}, {32'h0, 32'h0008_0201});
      chk("post_rst_ctrl", {log_addr[1], log_wdata[1]}, {32'h4, 32'h0001_0111});
    end
    stat_after = 1;
    xfer(8'hC3, 1, got, ok, lat, viol);
    chk("post_rst_rx", {ok, got}, {1'b1, 8'hC3});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_icb_seq.md
UART_ICB_SEQ -- requirements
Module: uart_icb_seq

Interface
REQ-001 SHALL have parameter CSR_ADDR, 32'h0000_0000: UART CSR register address.
REQ-002 SHALL have parameter CTRL_ADDR, 32'h0000_0004: UART CTRL register address.
REQ-003 SHALL have parameter DATA_ADDR, 32'h0000_0008: UART DATA register address.
REQ-004 SHALL have parameter STAT_BIT, 4: CSR bit that flags a received byte is available.
REQ-005 SHALL have parameter POLL_MAX, 1024: maximum CSR polls per byte before timeout; minimum 1.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous and active-low.
- cfg_start  in  1  pulse; start the configuration sequence.
- cfg_csr  in  32  value written to CSR.
- cfg_ctrl  in  32  value written to CTRL.
- cfg_done  out  1  level; configuration complete.
- busy  out  1  high in any state except IDLE and READY.
- err_timeout  out  1  sticky poll timeout.
- tx_valid / tx_ready  in / out  1 / 1  byte-in handshake.
- tx_data  in  8  byte to send.
- rx_valid / rx_ready  out / in  1 / 1  byte-out handshake.
- rx_data  out  8  received byte.
- icb_cmd_valid / icb_cmd_ready  out / in  1 / 1  ICB command handshake.
- icb_cmd_addr  out  32  command address.
- icb_cmd_read  out  1  1 = read, 0 = write.
- icb_cmd_wdata  out  32  write data.
- icb_rsp_valid / icb_rsp_ready  in / out  1 / 1  ICB response handshake.
- icb_rsp_rdata  in  32  read data.

Function
REQ-007 SHALL use states IDLE, CFG_CSR, CFG_CTRL, READY, WR_DATA, POLL, RD_DATA, OUT.
REQ-008 Each bus state SHALL have two phases:
- CMD: icb_cmd_valid=1; addr, read and wdata held stable until icb_cmd_ready.
- RSP: icb_rsp_ready=1 until icb_rsp_valid.
REQ-009 SHALL allow at most one outstanding ICB transaction, and SHALL never assert icb_cmd_valid while in the RSP phase.
REQ-010 IDLE or READY with cfg_start=1 SHALL move to CFG_CSR, clear cfg_done and clear err_timeout; cfg_start in any other state SHALL be ignored.
REQ-011 CFG_CSR SHALL write cfg_csr to CSR_ADDR, then go to CFG_CTRL.
REQ-012 CFG_CTRL SHALL write cfg_ctrl to CTRL_ADDR; on its response it SHALL set cfg_done=1 and go to READY.
REQ-013 tx_ready SHALL be 1 only in READY.
REQ-014 On a tx handshake SHALL latch tx_data and go to WR_DATA; icb_cmd_valid rises in the next cycle.
REQ-015 WR_DATA SHALL write {24'b0, tx_data} to DATA_ADDR, then go to POLL with poll_cnt=0.
REQ-016 POLL SHALL read CSR_ADDR, then on the response:
- rdata[STAT_BIT]=1: go to RD_DATA.
- otherwise, poll_cnt+1 < POLL_MAX: increment poll_cnt and issue a new read in the next cycle.
- otherwise: set err_timeout=1 and go to READY with no rx output.
REQ-017 RD_DATA SHALL read DATA_ADDR, register rdata[7:0] into rx_data, and go to OUT.
REQ-018 OUT SHALL hold rx_valid=1 with rx_data stable until rx_ready, then go to READY.
REQ-019 poll_cnt SHALL be 11 bits, sized for POLL_MAX ≤ 2048, and SHALL never wrap.
REQ-020 Upper response bits SHALL be ignored.
REQ-021 With icb_cmd_ready=1 and icb_rsp_valid one cycle after the command, one byte with a single poll SHALL take 8 cycles from tx handshake to rx_valid.
REQ-022 rx_ready held 0 SHALL stall the block in OUT indefinitely, with no ICB activity.

Reset
REQ-023 While rst_n=0, all outputs SHALL be 0, including icb_cmd_addr, icb_cmd_wdata, rx_data, cfg_done and err_timeout.
REQ-024 While rst_n=0, the state SHALL be IDLE and poll_cnt SHALL be 0.
REQ-025 Reset in the middle of a transaction SHALL abandon it; any late icb_rsp_valid after reset SHALL be ignored because icb_rsp_ready=0 in IDLE.
REQ-026 After reset, no ICB command SHALL be issued before cfg_start.

Structure
REQ-027 Package uart_seq_pkg SHALL hold the state enum, the default register addresses and STAT_BIT.
REQ-028 Sub-module uart_icb_xact SHALL perform one ICB transaction (start, addr, read, wdata -> done, rdata) and SHALL be used for all bus states.

Verification
REQ-029 Config: cfg_csr=32'h0008_0201, cfg_ctrl=32'h0001_0111, cfg_start -> writes to 0x0 then 0x4 in that order; cfg_done=1 one cycle after the second response.
REQ-030 Loopback: slave model returns CSR[4]=1 on the 3rd poll and DATA=0xA5; send tx 0xA5 -> one write 0x000000A5 to 0x8, three CSR reads, one DATA read, rx_data=0xA5.
REQ-031 Backpressure: icb_cmd_ready low for 5 cycles on each command -> addr and wdata stable throughout; results identical to the no-stall run.
REQ-032 Timeout: POLL_MAX=4 and CSR[4] always 0 -> exactly 4 CSR reads, err_timeout=1, rx_valid never asserted, tx_ready=1 again.
REQ-033 Stream: 256 bytes 0x00..0xFF with rx_ready randomly low -> 256 rx bytes in order, and no tx_ready while rx_valid is pending.
REQ-034 Reset mid-POLL with a pending response -> all outputs 0; a late rsp is not accepted; a new cfg_start reconfigures cleanly.
